// File: rtl/drra_call_sequencer_if.sv
// Control/status and fabric call/ret bundle between the APB register block and the sequencer.
// Handshake: start, abort and irq_clr are single-cycle request pulses sampled on clk_in; start_err answers a rejected start one cycle later; call is a single-cycle pulse per cell and ret is a level whose rising edge marks completion.
interface drra_call_sequencer_if #(
  parameter int NUM_CELLS = 2,
  parameter int CNT_W     = 32
);
  logic                 start;
  logic                 abort;
  logic [NUM_CELLS-1:0] cell_mask;
  logic [CNT_W-1:0]     timeout_cycles;
  logic                 irq_en;
  logic                 irq_clr;
  logic [NUM_CELLS-1:0] ret;
  logic [NUM_CELLS-1:0] call;
  logic                 busy;
  logic                 done;
  logic                 timed_out;
  logic                 start_err;
  logic [NUM_CELLS-1:0] ret_status;
  logic [CNT_W-1:0]     cycle_count;
  logic                 irq;
  logic [2:0]           dbg_state;

  modport master (
    output start, abort, cell_mask, timeout_cycles, irq_en, irq_clr, ret,
    input  call, busy, done, timed_out, start_err, ret_status, cycle_count, irq, dbg_state
  );

  modport slave (
    input  start, abort, cell_mask, timeout_cycles, irq_en, irq_clr, ret,
    output call, busy, done, timed_out, start_err, ret_status, cycle_count, irq, dbg_state
  );
endinterface

// File: rtl/drra_call_sequencer.sv
// Launches staggered call pulses to the selected DRRA cells, collects their ret edges,
// counts run cycles, enforces an optional timeout and raises a maskable interrupt.
module drra_call_sequencer #(
  parameter int NUM_CELLS = 2,
  parameter int CNT_W     = 32
) (
  input logic                  clk_in,
  input logic                  reset_int,
  drra_call_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_RUN     = 3'd2,
    S_DONE    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [NUM_CELLS-1:0] r_mask;
  logic [NUM_CELLS-1:0] r_issued;
  logic [NUM_CELLS-1:0] r_ret_q;
  logic [NUM_CELLS-1:0] r_ret_status;
  logic [CNT_W-1:0]     r_cycle_count;
  logic                 r_irq_pend;
  logic                 r_start_err;

  logic                 w_busy;
  logic                 w_can_start;
  logic                 w_start_ok;
  logic                 w_start_bad;
  logic [NUM_CELLS-1:0] w_pending;
  logic [NUM_CELLS-1:0] w_pick;
  logic                 w_last_pick;
  logic [NUM_CELLS-1:0] w_captured;
  logic [NUM_CELLS-1:0] w_status_nx;
  logic                 w_complete;
  logic                 w_tmo_hit;
  logic                 w_enter_term;
  logic [NUM_CELLS-1:0] w_call;

  assign w_busy      = (r_state == S_LAUNCH) || (r_state == S_RUN);
  assign w_can_start = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_TIMEOUT);
  assign w_start_ok  = bus.start && w_can_start && (bus.cell_mask != '0);
  assign w_start_bad = bus.start && !w_start_ok;

  // Lowest set, not-yet-issued mask bit; isolating it keeps call one-hot.
  assign w_pending   = r_mask & ~r_issued;
  assign w_pick      = w_pending & (~w_pending + NUM_CELLS'(1));
  assign w_last_pick = ((w_pending & ~w_pick) == '0);

  // Only a rising ret on an issued, masked cell counts, so stale high levels are ignored.
  assign w_captured  = bus.ret & ~r_ret_q & r_mask & r_issued;
  assign w_status_nx = r_ret_status | w_captured;
  assign w_complete  = (w_status_nx == r_mask);
  assign w_tmo_hit   = (bus.timeout_cycles != '0) &&
                       (r_cycle_count == bus.timeout_cycles - CNT_W'(1));

  always_ff @(posedge clk_in or posedge reset_int) begin
    if (reset_int) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_call = '0;
    case (r_state)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (w_start_ok) w_next = S_LAUNCH;
      end
      S_LAUNCH: begin
        w_call = w_pick;
        if (bus.abort)       w_next = S_IDLE;
        else if (w_complete) w_next = S_DONE;
        else if (w_tmo_hit)  w_next = S_TIMEOUT;
        else if (w_last_pick) w_next = S_RUN;
      end
      S_RUN: begin
        if (bus.abort)       w_next = S_IDLE;
        else if (w_complete) w_next = S_DONE;
        else if (w_tmo_hit)  w_next = S_TIMEOUT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_enter_term = ((w_next == S_DONE) || (w_next == S_TIMEOUT)) && (w_next != r_state);

  always_ff @(posedge clk_in or posedge reset_int) begin
    if (reset_int) begin
      r_mask        <= '0;
      r_issued      <= '0;
      r_ret_q       <= '0;
      r_ret_status  <= '0;
      r_cycle_count <= '0;
      r_irq_pend    <= 1'b0;
      r_start_err   <= 1'b0;
    end else begin
      r_ret_q     <= bus.ret;
      r_start_err <= w_start_bad;
      if (w_start_ok) begin
        r_mask        <= bus.cell_mask;
        r_issued      <= '0;
        r_ret_status  <= '0;
        r_cycle_count <= '0;
      end else if (w_busy) begin
        r_issued     <= r_issued | w_call;
        r_ret_status <= w_status_nx;
        if (r_cycle_count != '1) r_cycle_count <= r_cycle_count + CNT_W'(1);
      end
      // Entry to a terminal state wins over a same-cycle clear.
      if (w_enter_term)     r_irq_pend <= 1'b1;
      else if (bus.irq_clr) r_irq_pend <= 1'b0;
    end
  end

  assign bus.call        = w_call;
  assign bus.busy        = w_busy;
  assign bus.done        = (r_state == S_DONE);
  assign bus.timed_out   = (r_state == S_TIMEOUT);
  assign bus.start_err   = r_start_err;
  assign bus.ret_status  = r_ret_status;
  assign bus.cycle_count = r_cycle_count;
  assign bus.irq         = r_irq_pend & bus.irq_en;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_drra_call_sequencer.sv
// Directed bench for drra_call_sequencer: stimulus pushes expected call pulses, start_err
// pulses and terminal-state snapshots; a negedge monitor pops and compares them.
module tb_drra_call_sequencer;
  localparam int NC = 2;
  localparam int CW = 32;

  logic clk_in    = 1'b0;
  logic reset_int = 1'b1;

  drra_call_sequencer_if #(.NUM_CELLS(NC), .CNT_W(CW)) bus ();

  drra_call_sequencer #(.NUM_CELLS(NC), .CNT_W(CW)) dut (
    .clk_in    (clk_in),
    .reset_int (reset_int),
    .bus       (bus)
  );

  // ---------------- clock / reset / cycle index ----------------
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // {cycle, call}, {cycle}, {cycle, done, timed_out, ret_status, cycle_count, irq}
  logic [33:0] call_q[$];
  logic [31:0] err_q[$];
  logic [68:0] end_q[$];

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic prev_term = 1'b0;
  always @(negedge clk_in) begin
    if (bus.call != '0) begin
      if (call_q.size() == 0) check("unexpected_call", 69'({cyc, bus.call}), 69'(0));
      else                    check("call", 69'({cyc, bus.call}), 69'(call_q.pop_front()));
    end
    if (bus.start_err) begin
      if (err_q.size() == 0) check("unexpected_start_err", 69'(cyc), 69'(0));
      else                   check("start_err", 69'(cyc), 69'(err_q.pop_front()));
    end
    if ((bus.done || bus.timed_out) && !prev_term) begin
      if (end_q.size() == 0)
        check("unexpected_end", 69'({cyc, bus.done, bus.timed_out}), 69'(0));
      else
        check("end_state", {cyc, bus.done, bus.timed_out, bus.ret_status, bus.cycle_count, bus.irq},
              end_q.pop_front());
    end
    prev_term <= bus.done || bus.timed_out;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_until(input int c);
    for (int n = 0; n < 1000 && cyc < c; n++) tick();
    if (cyc < c) check("wait_bound", 69'(cyc), 69'(c));
  endtask

  task automatic issue_start(input logic [NC-1:0] mask, input logic [CW-1:0] tmo);
    bus.cell_mask      = mask;
    bus.timeout_cycles = tmo;
    bus.start          = 1'b1;
  endtask

  task automatic clear_irq();
    bus.irq_clr = 1'b1;
    tick();
    bus.irq_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  int c0;
  initial begin
    bus.start          = 1'b1;
    bus.abort          = 1'b0;
    bus.cell_mask      = 2'b11;
    bus.timeout_cycles = '0;
    bus.irq_en         = 1'b1;
    bus.irq_clr        = 1'b0;
    bus.ret            = 2'b11;

    // Reset held with start and ret high: everything stays quiet.
    #12;
    check("rst_outputs", 69'({bus.call, bus.busy, bus.done, bus.timed_out, bus.start_err,
                              bus.ret_status, bus.irq, bus.dbg_state}), 69'(0));
    check("rst_count", 69'(bus.cycle_count), 69'(0));
    tick();
    reset_int = 1'b0;
    bus.start = 1'b0;
    bus.ret   = 2'b00;
    tick();
    tick();
    check("idle_after_reset", 69'({bus.dbg_state, bus.busy, bus.call}), 69'(0));

    // Run 1: mask 11, no timeout, staggered ret edges.
    c0 = cyc;
    issue_start(2'b11, 32'd0);
    call_q.push_back({32'(c0 + 1), 2'b01});
    call_q.push_back({32'(c0 + 2), 2'b10});
    end_q.push_back({32'(c0 + 10), 1'b1, 1'b0, 2'b11, 32'd9, 1'b1});
    tick();
    bus.start = 1'b0;
    wait_until(c0 + 5);
    bus.ret[0] = 1'b1;
    wait_until(c0 + 9);
    bus.ret[1] = 1'b1;
    wait_until(c0 + 12);
    check("irq_held", 69'({bus.irq, bus.done}), 69'(2'b11));
    clear_irq();
    check("irq_cleared", 69'(bus.irq), 69'(0));

    // Run 2: mask 10 with both ret levels already high; only a fresh rise of ret[1] counts.
    c0 = cyc;
    issue_start(2'b10, 32'd0);
    call_q.push_back({32'(c0 + 1), 2'b10});
    end_q.push_back({32'(c0 + 9), 1'b1, 1'b0, 2'b10, 32'd8, 1'b1});
    tick();
    bus.start = 1'b0;
    wait_until(c0 + 6);
    check("stale_ret_ignored", 69'({bus.busy, bus.ret_status}), 69'(3'b100));
    bus.ret[1] = 1'b0;
    wait_until(c0 + 8);
    bus.ret[1] = 1'b1;
    wait_until(c0 + 10);
    clear_irq();
    bus.ret = 2'b00;

    // Run 3: timeout 20, ret never rises; a start during RUN is rejected.
    c0 = cyc;
    issue_start(2'b01, 32'd20);
    call_q.push_back({32'(c0 + 1), 2'b01});
    err_q.push_back(32'(c0 + 11));
    end_q.push_back({32'(c0 + 21), 1'b0, 1'b1, 2'b00, 32'd20, 1'b1});
    tick();
    bus.start = 1'b0;
    wait_until(c0 + 10);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_until(c0 + 22);
    check("timeout_pend", 69'({bus.timed_out, bus.irq}), 69'(2'b11));
    clear_irq();

    // Run 4: completion lands on the timeout-match cycle; irq masked.
    bus.irq_en = 1'b0;
    c0 = cyc;
    issue_start(2'b01, 32'd20);
    call_q.push_back({32'(c0 + 1), 2'b01});
    end_q.push_back({32'(c0 + 21), 1'b1, 1'b0, 2'b01, 32'd20, 1'b0});
    tick();
    bus.start = 1'b0;
    wait_until(c0 + 20);
    bus.ret[0] = 1'b1;
    wait_until(c0 + 22);
    check("irq_masked", 69'(bus.irq), 69'(0));
    bus.irq_en = 1'b1;
    #1;
    check("irq_unmasked", 69'(bus.irq), 69'(1));
    clear_irq();
    bus.ret = 2'b00;

    // Run 5: abort during the first LAUNCH cycle; call[1] must never pulse.
    c0 = cyc;
    issue_start(2'b11, 32'd0);
    call_q.push_back({32'(c0 + 1), 2'b01});
    tick();
    bus.start = 1'b0;
    check("status_cleared_on_start", 69'(bus.ret_status), 69'(0));
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_to_idle", 69'({bus.dbg_state, bus.busy, bus.call, bus.irq}), 69'(0));
    wait_until(c0 + 6);

    // Zero mask in IDLE: rejected, state unchanged.
    c0 = cyc;
    issue_start(2'b00, 32'd0);
    err_q.push_back(32'(c0 + 1));
    tick();
    bus.start = 1'b0;
    tick();
    check("zero_mask_idle", 69'({bus.dbg_state, bus.busy}), 69'(0));

    // Run 6: normal run after the abort.
    c0 = cyc;
    issue_start(2'b11, 32'd0);
    call_q.push_back({32'(c0 + 1), 2'b01});
    call_q.push_back({32'(c0 + 2), 2'b10});
    end_q.push_back({32'(c0 + 7), 1'b1, 1'b0, 2'b11, 32'd6, 1'b1});
    tick();
    bus.start = 1'b0;
    wait_until(c0 + 4);
    bus.ret[0] = 1'b1;
    wait_until(c0 + 6);
    bus.ret[1] = 1'b1;
    wait_until(c0 + 8);
    clear_irq();
    bus.ret = 2'b00;

    // Reset asserted mid-LAUNCH drops call before the cycle's sample point.
    issue_start(2'b11, 32'd0);
    tick();
    bus.start = 1'b0;
    #1;
    reset_int = 1'b1;
    #1;
    check("reset_drops_call", 69'({bus.call, bus.busy, bus.ret_status, bus.dbg_state}), 69'(0));
    check("reset_clears_count", 69'(bus.cycle_count), 69'(0));
    tick();
    tick();
    reset_int = 1'b0;
    tick();
    tick();

    check("call_q_drained", 69'(call_q.size()), 69'(0));
    check("err_q_drained", 69'(err_q.size()), 69'(0));
    check("end_q_drained", 69'(end_q.size()), 69'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
